// File: rtl/toggle_rx.sv
// Toggle-coded (NRZI-style) line receiver: decodes bits, hunts for a sync word, then frames FRAME_WORDS words LSB first.
// Words appear one cycle after their last bit in a one-entry holding register; a word completing while it is full and unaccepted is dropped and flagged in overrun.
module toggle_rx #(
   parameter int                 DATA_W      = 8,
   parameter logic [DATA_W-1:0]  SYNC_PAT    = 8'h7E,
   parameter int                 FRAME_WORDS = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bit_en,
   input  logic              line_in,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              in_frame,
   output logic              overrun,
   input  logic              ovr_clr
);

   localparam int              BC_W      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(DATA_W - 1);
   localparam logic [BC_W-1:0] BIT_ONE   = BC_W'(1);
   localparam logic [7:0]      WORD_LAST = 8'(FRAME_WORDS - 1);

   localparam logic [0:0] HUNT = 1'b0;
   localparam logic [0:0] DATA = 1'b1;

   logic [0:0]        state_q,     state_d;
   logic              line_prev_q, line_prev_d;
   logic [DATA_W-1:0] shift_q,     shift_d;
   logic [BC_W-1:0]   bit_cnt_q,   bit_cnt_d;
   logic [7:0]        word_cnt_q,  word_cnt_d;
   logic [DATA_W-1:0] rx_data_q,   rx_data_d;
   logic              rx_valid_q,  rx_valid_d;
   logic              overrun_q,   overrun_d;

   logic              d_bit;
   logic [DATA_W-1:0] shift_upd;
   logic              word_done;
   logic              ovr_set;

   assign d_bit     = line_in ^ line_prev_q;
   assign shift_upd = {d_bit, shift_q[DATA_W-1:1]};

   // Bit decode, sync hunt and word framing
   always_comb begin
      state_d     = state_q;
      line_prev_d = line_prev_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      word_cnt_d  = word_cnt_q;
      word_done   = 1'b0;
      if (bit_en) begin
         line_prev_d = line_in;
         shift_d     = shift_upd;
         case (state_q)
            HUNT: begin
               if (shift_upd == SYNC_PAT) begin
                  state_d    = DATA;
                  shift_d    = '0;
                  bit_cnt_d  = '0;
                  word_cnt_d = '0;
               end
            end
            default: begin
               if (bit_cnt_q == BIT_LAST) begin
                  word_done = 1'b1;
                  bit_cnt_d = '0;
                  if (word_cnt_q == WORD_LAST) begin
                     state_d    = HUNT;
                     shift_d    = '0;
                     word_cnt_d = '0;
                  end else begin
                     word_cnt_d = word_cnt_q + 8'd1;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_ONE;
               end
            end
         endcase
      end
   end

   // A word completing on an accept edge replaces the outgoing one with no bubble
   always_comb begin
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      ovr_set    = 1'b0;
      if (word_done) begin
         if (!rx_valid_q || rx_ready) begin
            rx_data_d  = shift_upd;
            rx_valid_d = 1'b1;
         end else begin
            ovr_set = 1'b1;
         end
      end else if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end
      if (ovr_set) begin
         overrun_d = 1'b1;
      end else if (ovr_clr) begin
         overrun_d = 1'b0;
      end else begin
         overrun_d = overrun_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= HUNT;
         line_prev_q <= 1'b0;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         word_cnt_q  <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         line_prev_q <= line_prev_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         word_cnt_q  <= word_cnt_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign in_frame = (state_q == DATA);
   assign overrun  = overrun_q;

endmodule

// File: tb/tb_toggle_rx.sv
// Scoreboarded random test of toggle_rx against a bit-level behavioural model.
module tb_toggle_rx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       bit_en = 1'b0;
   logic       line_in = 1'b0;
   logic       rx_ready = 1'b0;
   logic       ovr_clr = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       in_frame;
   logic       overrun;

   always #5 clk = ~clk;

   toggle_rx #(.DATA_W(8), .SYNC_PAT(8'h7E), .FRAME_WORDS(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .bit_en   (bit_en),
      .line_in  (line_in),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .in_frame (in_frame),
      .overrun  (overrun),
      .ovr_clr  (ovr_clr)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: recent decoded bits as a queue, words accumulated bit by bit
   logic [7:0] sync_v = 8'h7E;
   bit         hist[$];
   bit         m_prev, m_data, m_full, m_ovr;
   int         m_bitpos, m_wcnt;
   logic [7:0] m_acc, m_hold;
   logic [7:0] exp_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic hist_clear();
      hist.delete();
      repeat (8) hist.push_back(1'b0);
   endtask

   task automatic model_reset();
      m_prev = 0; m_data = 0; m_full = 0; m_ovr = 0;
      m_bitpos = 0; m_wcnt = 0; m_acc = '0; m_hold = '0;
      hist_clear();
      exp_q.delete();
   endtask

   task automatic model_step();
      bit         d, done, ok, set_ovr;
      logic [7:0] word;
      done = 0; set_ovr = 0; word = '0;
      if (bit_en) begin
         d = line_in ^ m_prev;
         m_prev = line_in;
         if (!m_data) begin
            hist.push_back(d);
            void'(hist.pop_front());
            ok = 1;
            for (int i = 0; i < 8; i++) if (hist[i] != sync_v[i]) ok = 0;
            if (ok) begin
               m_data = 1; m_bitpos = 0; m_wcnt = 0; m_acc = '0;
               hist_clear();
            end
         end else begin
            m_acc[m_bitpos] = d;
            m_bitpos++;
            if (m_bitpos == 8) begin
               done = 1; word = m_acc; m_bitpos = 0; m_wcnt++;
               if (m_wcnt == 4) begin
                  m_data = 0; m_wcnt = 0;
                  hist_clear();
               end
            end
         end
      end
      if (done) begin
         if (!m_full || rx_ready) begin
            m_full = 1; m_hold = word;
            exp_q.push_back(word);
         end else begin
            set_ovr = 1;
         end
      end else if (m_full && rx_ready) begin
         m_full = 0;
      end
      if (set_ovr) m_ovr = 1;
      else if (ovr_clr) m_ovr = 0;
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) model_reset();
      else model_step();
   end

   // Monitor: compare status every cycle, pop the scoreboard on each transfer
   always @(negedge clk) begin
      logic [7:0] e;
      chk("rx_valid", 32'(rx_valid), 32'(m_full));
      chk("in_frame", 32'(in_frame), 32'(m_data));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      if (rx_valid) chk("rx_data_hold", 32'(rx_data), 32'(m_hold));
      if (rx_valid && rx_ready) begin
         if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL xfer_unexpected at %0t: got %0h expected no word", $time, rx_data);
         end else begin
            e = exp_q.pop_front();
            chk("xfer_word", 32'(rx_data), 32'(e));
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish");
      $fatal(1);
   end

   bit line_lvl = 1'b0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // r: 0/1 = fixed rx_ready, 2 = random ready with occasional ovr_clr
   task automatic set_rdy(input int r);
      if (r == 2) begin
         rx_ready = 1'($urandom_range(0, 1));
         ovr_clr  = ($urandom_range(0, 15) == 0);
      end else begin
         rx_ready = r[0];
         ovr_clr  = 1'b0;
      end
   endtask

   task automatic send_bit(input bit b, input int gap, input int r);
      repeat (gap) begin
         bit_en  = 1'b0;
         line_in = 1'($urandom_range(0, 1));
         set_rdy(r);
         tick();
      end
      bit_en   = 1'b1;
      line_lvl = line_lvl ^ b;
      line_in  = line_lvl;
      set_rdy(r);
      tick();
      bit_en  = 1'b0;
      line_in = line_lvl;
   endtask

   task automatic send_byte(input logic [7:0] v, input int gap, input int r);
      for (int i = 0; i < 8; i++) send_bit(v[i], gap, r);
   endtask

   initial begin
      logic [7:0] w;
      rst = 1'b1;
      tick();
      chk("reset_rx_valid", 32'(rx_valid), 32'd0);
      chk("reset_rx_data", 32'(rx_data), 32'd0);
      chk("reset_in_frame", 32'(in_frame), 32'd0);
      chk("reset_overrun", 32'(overrun), 32'd0);
      rst = 1'b0;
      tick();

      // Sync then a full frame with the consumer always ready
      send_byte(8'h7E, 0, 1);
      chk("sync_in_frame", 32'(in_frame), 32'd1);
      chk("sync_rx_valid", 32'(rx_valid), 32'd0);
      send_byte(8'hA5, 0, 1);
      send_byte(8'h3C, 0, 1);
      send_byte(8'hFF, 0, 1);
      send_byte(8'h00, 0, 1);
      chk("frame_end_in_frame", 32'(in_frame), 32'd0);
      chk("last_word_valid", 32'(rx_valid), 32'd1);
      chk("last_word_data", 32'(rx_data), 32'h00);
      tick();
      chk("last_word_pulse", 32'(rx_valid), 32'd0);

      // Same frame with a sparse strobe and line noise between strobes
      send_byte(8'h7E, 2, 1);
      send_byte(8'hA5, 2, 1);
      send_byte(8'h3C, 2, 1);
      send_byte(8'hFF, 2, 1);
      send_byte(8'h00, 2, 1);
      tick();

      // Consumer stalled for a whole frame
      send_byte(8'h7E, 0, 0);
      send_byte(8'h11, 0, 0);
      send_byte(8'h22, 0, 0);
      chk("ovr_after_word2", 32'(overrun), 32'd1);
      send_byte(8'h33, 0, 0);
      send_byte(8'h44, 0, 0);
      chk("stall_data", 32'(rx_data), 32'h11);
      chk("stall_valid", 32'(rx_valid), 32'd1);
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      chk("ovr_clr", 32'(overrun), 32'd0);
      rx_ready = 1'b1;
      tick();
      chk("stall_drain", 32'(rx_valid), 32'd0);

      // Accept on the very edge the next word completes
      send_byte(8'h7E, 0, 1);
      send_byte(8'h55, 0, 0);
      w = 8'h22;
      for (int i = 0; i < 7; i++) send_bit(w[i], 0, 0);
      send_bit(w[7], 0, 1);
      chk("same_edge_valid", 32'(rx_valid), 32'd1);
      chk("same_edge_data", 32'(rx_data), 32'h22);
      chk("same_edge_ovr", 32'(overrun), 32'd0);
      send_byte(8'h33, 0, 1);
      send_byte(8'h44, 0, 1);
      tick();

      // Reset mid-word with a word held
      send_byte(8'h7E, 0, 1);
      send_byte(8'h66, 0, 0);
      w = 8'h77;
      for (int i = 0; i < 4; i++) send_bit(w[i], 0, 0);
      chk("pre_reset_valid", 32'(rx_valid), 32'd1);
      rst = 1'b1;
      line_lvl = 1'b0;
      line_in = 1'b0;
      #1;
      chk("async_rst_valid", 32'(rx_valid), 32'd0);
      chk("async_rst_data", 32'(rx_data), 32'd0);
      chk("async_rst_in_frame", 32'(in_frame), 32'd0);
      tick();
      rst = 1'b0;
      send_byte(8'h99, 0, 1);
      send_byte(8'h12, 0, 1);
      chk("no_valid_before_resync", 32'(rx_valid), 32'd0);
      chk("no_frame_before_resync", 32'(in_frame), 32'd0);

      // Random frames with leading garbage, random gaps and random ready
      for (int f = 0; f < 20; f++) begin
         int gap;
         gap = $urandom_range(0, 2);
         repeat ($urandom_range(0, 12)) send_bit(1'($urandom_range(0, 1)), gap, 2);
         send_byte(8'h7E, gap, 2);
         repeat (4) send_byte(8'($urandom), gap, 2);
      end

      ovr_clr  = 1'b0;
      rx_ready = 1'b1;
      bit_en   = 1'b0;
      repeat (4) tick();
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
